// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer around one full-adder cell, LSB first, one bit per clock.
// Start to done is WIDTH+1 cycles; start is only taken in IDLE, so callers retry until busy is low.

module adder1bit (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic c_out
);
   assign sum   = a ^ b ^ c_in;
   assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic             abort,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             c_out,
   output logic             overflow
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] sa, sb, sr, sr_nx;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             last;
   logic             cell_sum, cell_cout;

   adder1bit u_cell (
      .a     (sa[0]),
      .b     (sb[0]),
      .c_in  (carry),
      .sum   (cell_sum),
      .c_out (cell_cout)
   );

   assign last  = (cnt == CW'(WIDTH - 1));
   assign sr_nx = {cell_sum, sr[WIDTH-1:1]};
   assign busy  = (state != S_IDLE);
   assign done  = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_RUN;
         // abort wins over the final-bit transition
         S_RUN:   if (abort) state_nx = S_IDLE;
                  else if (last) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sa       <= '0;
         sb       <= '0;
         sr       <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         result   <= '0;
         c_out    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  sa    <= a;
                  sb    <= sub ? ~b : b;
                  carry <= sub;
                  cnt   <= '0;
               end
            end
            S_RUN: begin
               if (!abort) begin
                  sa    <= sa >> 1;
                  sb    <= sb >> 1;
                  sr    <= sr_nx;
                  carry <= cell_cout;
                  cnt   <= cnt + CW'(1);
                  if (last) begin
                     // carry still holds the carry into the MSB here
                     result   <= sr_nx;
                     c_out    <= cell_cout;
                     overflow <= carry ^ cell_cout;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8 with hand-computed results.
module tb_serial_add_ctrl;
   logic       clk, rst_n, start, sub, abort;
   logic [7:0] a, b;
   logic       busy, done, c_out, overflow;
   logic [7:0] result;

   int tests = 0;
   int fails = 0;

   serial_add_ctrl #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .sub      (sub),
      .abort    (abort),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .c_out    (c_out),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic sv);
      @(negedge clk);
      a = av; b = bv; sub = sv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 1;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_lat"}, n, 9);
   endtask

   task automatic op_check(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input logic sv, input logic [7:0] er, input logic ec, input logic eo);
      start_op(av, bv, sv);
      check({tag, "_busy"}, busy, 1);
      wait_done(tag);
      check({tag, "_res"}, result, er);
      check({tag, "_cout"}, c_out, ec);
      check({tag, "_ovf"}, overflow, eo);
      @(negedge clk);
      check({tag, "_idle"}, busy, 0);
      check({tag, "_donelow"}, done, 0);
   endtask

   task automatic abort_test(input string tag, input int n);
      bit seen;
      start_op(8'h01, 8'h01, 1'b0);
      repeat (n - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check({tag, "_busy"}, busy, 0);
      seen = 0;
      repeat (12) begin
         if (done) seen = 1;
         @(negedge clk);
      end
      check({tag, "_nodone"}, seen, 0);
      check({tag, "_res"}, result, 8'h96);
   endtask

   initial begin
      int pulses;
      int t[3];
      int cyc;
      bit seen;

      rst_n = 1'b0; start = 1'b0; sub = 1'b0; abort = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_res", result, 0);
      check("rst_cout", c_out, 0);
      check("rst_ovf", overflow, 0);

      op_check("add1", 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1);
      abort_test("abort3", 3);
      abort_test("abortlast", 8);
      op_check("sub1", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0);
      op_check("sub2", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
      op_check("addwrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);

      // start held high for 30 cycles
      @(negedge clk);
      a = 8'h05; b = 8'h03; sub = 1'b0; start = 1'b1;
      pulses = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (done) begin
            if (pulses < 3) t[pulses] = i;
            pulses++;
         end
      end
      start = 1'b0;
      check("held_pulses", pulses, 3);
      check("held_first", t[0], 9);
      check("held_gap1", t[1] - t[0], 10);
      check("held_gap2", t[2] - t[1], 10);
      repeat (3) @(negedge clk);
      check("held_idle", busy, 0);
      check("held_res", result, 8'h08);

      // operand and start changes during RUN/DONE are ignored
      start_op(8'h21, 8'h13, 1'b0);
      cyc = 1;
      while (!done && cyc < 40) begin
         a = 8'($urandom); b = 8'($urandom); sub = ~sub; start = ~start;
         @(negedge clk);
         cyc++;
      end
      check("ign_lat", cyc, 9);
      start = 1'b1;
      a = 8'hFF; b = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      check("ign_busy", busy, 0);
      check("ign_res", result, 8'h34);
      check("ign_ovf", overflow, 0);
      seen = 0;
      repeat (12) begin
         if (busy) seen = 1;
         @(negedge clk);
      end
      check("ign_nostart", seen, 0);

      // synchronous reset mid-RUN
      start_op(8'h55, 8'h0F, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mrst_busy", busy, 0);
      check("mrst_done", done, 0);
      check("mrst_res", result, 0);
      check("mrst_cout", c_out, 0);
      check("mrst_ovf", overflow, 0);
      seen = 0;
      repeat (12) begin
         if (done) seen = 1;
         @(negedge clk);
      end
      check("mrst_nodone", seen, 0);
      op_check("post_rst", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add/subtract sequencer built around one instance of the single-bit full-adder cell `adder1bit`. It accepts two WIDTH-bit operands with a start handshake and feeds them LSB-first through the cell, one bit per clock. The carry is held in a flop between bits, and the block reports the result with carry-out and signed overflow. It serves as the low-area arithmetic engine for pipeline stages that can tolerate multi-cycle latency.

## Interface
- WIDTH, 32: operand/result width in bits; legal range ≥ 2.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- sub  in  1  0 = A+B, 1 = A−B; sampled with start.
- abort  in  1  cancel; honoured only in RUN.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse; result, c_out and overflow are valid.
- result  out  WIDTH  sum/difference; registered; holds until the next completed operation.
- c_out  out  1  final carry; for subtract, 1 = no borrow.
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE.
- IDLE with start=1:
  - load shift reg SA ← a;
  - load SB ← (sub ? ~b : b);
  - carry ← sub;
  - bit counter ← 0;
  - go to RUN.
- IDLE with start=0: stay in IDLE.
- Each RUN cycle:
  - the cell receives SA[0], SB[0], carry;
  - its sum bit shifts into the MSB of internal shift reg SR (SR shifts right);
  - SA and SB shift right; carry ← cell c_out; counter +1.
- On the RUN cycle with counter = WIDTH−1:
  - capture cmsb ← carry (the carry into the MSB) before the update;
  - next state DONE;
  - result ← final SR value, including this cycle's sum bit;
  - c_out ← cell c_out; overflow ← cmsb XOR cell c_out.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- abort=1 in RUN: next state IDLE.
  - result, c_out and overflow keep their previous values; done is not asserted.
  - abort takes priority over the final-bit transition.
- Ignored inputs:
  - start in RUN or DONE;
  - abort in IDLE or DONE;
  - start and abort both high in IDLE: start is accepted.
- Arithmetic is modulo 2^WIDTH. Operand inputs may change freely after the start cycle.

## Timing
- Reset (rst_n=0 at an edge):
  - state IDLE; busy=0, done=0, result=0, c_out=0, overflow=0;
  - SA, SB, SR, carry and counter cleared.
  - This takes effect regardless of state, including mid-RUN; there is no partial result and no done pulse.
- Start sampled at edge k:
  - busy=1 from edge k through edge k+WIDTH+1;
  - RUN occupies edges k+1 … k+WIDTH, processing bits 0 … WIDTH−1;
  - DONE (done=1, outputs valid) is the cycle after edge k+WIDTH;
  - IDLE after edge k+WIDTH+1.
- Latency from start sample to done high: WIDTH+1 cycles.
- Minimum spacing between accepted starts: WIDTH+2 cycles. If start is held high continuously, it is accepted once every WIDTH+2 cycles.
- Outputs result, c_out and overflow change only at the RUN→DONE edge or on reset. They are stable at all other times.
- The adder cell is the only combinational path from register outputs to register inputs in the datapath.

## Test plan
- WIDTH=8, a=0x3C, b=0x5A, sub=0 → after 9 cycles done=1, result=0x96, c_out=0, overflow=1.
- a=0x10, b=0x01, sub=1 → result=0x0F, c_out=1, overflow=0. Also a=0x80, b=0x01, sub=1 → result=0x7F, overflow=1.
- a=0xFF, b=0x01, sub=0 → result=0x00, c_out=1, overflow=0. Then start held high for 30 cycles → exactly 3 done pulses, spaced 10 cycles apart.
- Abort:
  - after 0x3C+0x5A completes, start 0x01+0x01 and assert abort on the 3rd RUN cycle → busy=0 next cycle, no done, result stays 0x96;
  - abort asserted on the final RUN cycle → same behaviour.
- Start pulses and a/b changes during RUN and DONE are ignored: result matches the operands captured at the accepted start.
- rst_n=0 for 1 cycle mid-RUN → next cycle all outputs 0 and state IDLE. A following start of 0x7F+0x01 → result=0x80, overflow=1.
